mux_tdm_sel: RTL
================

// Module: mux_tdm_sel
// PURPOSE
//  Parametrised, registered N-channel data selector; successor to the 8:1 gate-level mux.
//  Two modes: manual (channel chosen by s) and round-robin scan over channels with
//  d_valid set. Output is a single registered word with valid/ready handshake plus
//  the channel index; sits between parallel sources and one shared downstream sink.
// PARAMETERS
//  N_CH   8   number of input channels, >=2, need not be a power of two
//  DW     8   data width per channel, >=1
//  SEL_W  derived localparam = $clog2(N_CH); not overridable
// PORTS
//  clk      in   1         single clock, rising edge
//  rst_n    in   1         asynchronous assert, active-low reset
//  d        in   N_CH*DW   channel data; channel k = d[k*DW +: DW]
//  d_valid  in   N_CH      per-channel data valid
//  d_ack    out  N_CH      one-hot pulse: channel captured into output register this cycle
//  mode     in   1         0 = manual select, 1 = round-robin scan
//  s        in   SEL_W     manual channel select (ignored in scan mode)
//  y        out  DW        selected data (registered)
//  y_ch     out  SEL_W     channel index of y
//  y_valid  out  1         y/y_ch hold a word
//  y_ready  in   1         sink accepts word when y_valid && y_ready
// BEHAVIOUR
//  Reset (rst_n=0, async): y=0, y_ch=0, y_valid=0, d_ack=0, ptr=N_CH-1 (first scan grant = ch0).
//  load = !y_valid || y_ready. Output register updates only when load=1; else y, y_ch, y_valid hold.
//  Manual (mode=0): cand = s; hit = (s < N_CH) && d_valid[s]. s >= N_CH counts as no hit.
//  Scan (mode=1): cand = first k with d_valid[k], searching cyclically from ptr+1 (wrapping
//    N_CH-1 -> 0); hit = |d_valid. ptr <= cand on capture; ptr unchanged otherwise.
//  On load: hit -> y<=d[cand], y_ch<=cand, y_valid<=1, d_ack[cand]=1 that cycle (combinational
//    from registered-load decision). No hit -> y_valid<=0; y, y_ch hold old values.
//  Latency: 1 clk from d_valid/select to y_valid. Full throughput: one word per clk when y_ready=1.
//  Backpressure: y_valid=1 && y_ready=0 -> no capture, d_ack=0, y stable (no drop, no overwrite).
//  Simultaneous accept + new hit: same edge retires old word and loads new one (no bubble).
//  Mode/s change: takes effect at next load only; never alters a held word. ptr kept across modes.
//  Single requester in scan mode is granted every cycle (no forced rotation gap).
//  Reset mid-transfer: held word discarded, state as above.
//  Manual mode uses full N_CH decode; every channel 0..N_CH-1 reaches y.
// CONFIGURATION
//  Macro MUX_TDM_PARITY_EN:
//   defined   -> extra output y_par (1 bit) = ^y, registered with y, reset 0, held with y.
//   undefined -> no y_par port; no parity logic. All other behaviour identical.
// STRUCTURE
//  Shared package mux_pkg: mode encoding constants (MODE_MANUAL=1'b0, MODE_SCAN=1'b1) and
//   clog2 helper if the toolflow lacks $clog2.
//  One sub-module: rr_pick (N_CH-wide cyclic first-one finder: req, ptr -> cand, hit),
//   pure combinational; everything sequential lives in mux_tdm_sel.
// TESTING
//  Manual sweep: N_CH=8, DW=8, d[k]=8'hA0+k, all valid, y_ready=1, s=0..7 -> y=A0..A7,
//   y_ch=s, one cycle later each; explicitly confirms ch3 -> 8'hA3.
//  Scan fairness: d_valid=8'b1010_0101, y_ready=1 -> y_ch sequence 0,2,5,7,0,2... after reset.
//  Backpressure: word on ch2 valid, y_ready=0 for 4 clks -> y, y_ch stable, d_ack=0;
//   y_ready=1 -> accepted, next word loaded same edge.
//  Empty/no-hit: d_valid=0 (scan) or s=9 with N_CH=10, d_valid[9]=0 -> y_valid drops to 0
//   after accept; non-power-of-2 N_CH=5 with s=6 -> y_valid=0.
//  Reset mid-operation: assert rst_n during held word -> y_valid=0 immediately (async);
//   after release first scan grant is lowest valid channel.
//  Parity build (MUX_TDM_PARITY_EN): y=8'hA3 -> y_par=0; y=8'hA7 -> y_par=1; absent build
//   elaborates without y_par.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants for the TDM channel selector
package mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_tdm_sel_if.sv
// rtl/mux_tdm_sel_if.sv - source/sink bundle of the selector (y_par present under MUX_TDM_PARITY_EN)
interface mux_tdm_sel_if #(
  parameter int N_CH = 8,
  parameter int DW   = 8
);
  localparam int SEL_W = $clog2(N_CH);

  logic [N_CH*DW-1:0] d;
  logic [N_CH-1:0]    d_valid;
  logic [N_CH-1:0]    d_ack;
  logic               mode;
  logic [SEL_W-1:0]   s;
  logic [DW-1:0]      y;
  logic [SEL_W-1:0]   y_ch;
  logic               y_valid;
  logic               y_ready;
`ifdef MUX_TDM_PARITY_EN
  logic               y_par;

  modport slave (
    input  d, d_valid, mode, s, y_ready,
    output d_ack, y, y_ch, y_valid, y_par
  );

  modport master (
    output d, d_valid, mode, s, y_ready,
    input  d_ack, y, y_ch, y_valid, y_par
  );
`else
  modport slave (
    input  d, d_valid, mode, s, y_ready,
    output d_ack, y, y_ch, y_valid
  );

  modport master (
    output d, d_valid, mode, s, y_ready,
    input  d_ack, y, y_ch, y_valid
  );
`endif

endinterface

// File: rtl/mux_tdm_sel_rr_pick.sv
// rtl/mux_tdm_sel_rr_pick.sv - cyclic first-one finder starting just after ptr
module rr_pick #(
  parameter int N_CH  = 8,
  parameter int SEL_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] cand,
  output logic             hit
);

  // Two passes: channels above ptr first, then wrap to 0..ptr, so ptr itself is last.
  always_comb begin
    cand = '0;
    hit  = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (!hit && (k > int'(ptr)) && req[k]) begin
        hit  = 1'b1;
        cand = SEL_W'(k);
      end
    end
    for (int k = 0; k < N_CH; k++) begin
      if (!hit && (k <= int'(ptr)) && req[k]) begin
        hit  = 1'b1;
        cand = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/mux_tdm_sel.sv
// rtl/mux_tdm_sel.sv - registered N-channel selector, manual or round-robin; parity via MUX_TDM_PARITY_EN
module mux_tdm_sel
  import mux_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_tdm_sel_if.slave bus
);

  localparam int SEL_W = $clog2(N_CH);

  logic [SEL_W-1:0] ptr_q;
  logic [DW-1:0]    y_q;
  logic [SEL_W-1:0] y_ch_q;
  logic             y_valid_q;

  logic [SEL_W-1:0] scan_cand;
  logic             scan_hit;
  logic             man_hit;
  logic [SEL_W-1:0] cand;
  logic             hit;
  logic [DW-1:0]    cand_data;
  logic             load;
  logic             capture;

  rr_pick #(
    .N_CH  (N_CH),
    .SEL_W (SEL_W)
  ) u_pick (
    .req  (bus.d_valid),
    .ptr  (ptr_q),
    .cand (scan_cand),
    .hit  (scan_hit)
  );

  // Manual decode by comparison, so selects at or beyond N_CH simply never hit.
  always_comb begin
    man_hit = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.s == SEL_W'(k)) begin
        man_hit = bus.d_valid[k];
      end
    end
  end

  // Pick the candidate for the current mode and fetch its data word.
  always_comb begin
    cand      = (bus.mode == MODE_SCAN) ? scan_cand : bus.s;
    hit       = (bus.mode == MODE_SCAN) ? scan_hit  : man_hit;
    cand_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (cand == SEL_W'(k)) begin
        cand_data = bus.d[k*DW +: DW];
      end
    end
  end

  assign load    = !y_valid_q || bus.y_ready;
  assign capture = load && hit;

  // Acknowledge the captured channel; held low while reset is asserted.
  always_comb begin
    bus.d_ack = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (rst_n && capture && (cand == SEL_W'(k))) begin
        bus.d_ack[k] = 1'b1;
      end
    end
  end

  // Output register: loads when empty or being drained; a miss only clears valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      ptr_q     <= SEL_W'(N_CH - 1);
    end else if (load) begin
      if (hit) begin
        y_q       <= cand_data;
        y_ch_q    <= cand;
        y_valid_q <= 1'b1;
        if (bus.mode == MODE_SCAN) begin
          ptr_q <= cand;
        end
      end else begin
        y_valid_q <= 1'b0;
      end
    end
  end

`ifdef MUX_TDM_PARITY_EN
  logic y_par_q;

  // Parity tracks y exactly: same load and hit conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par_q <= 1'b0;
    end else if (capture) begin
      y_par_q <= ^cand_data;
    end
  end

  assign bus.y_par = y_par_q;
`endif

  assign bus.y       = y_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;

endmodule
